// File: rtl/instruction_queue_pkg.sv
// Shared types for the IR-to-IQ path: machine-wide sizing constants and the
// decoded control word carried through the issue queue.
package rv32i_types;
    localparam int IQ_DEPTH = 8;
endpackage

package tomasula_types;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;

    typedef logic iq_entry_valid;

    localparam int CTL_WORD_W = $bits(ctl_word);
endpackage

// File: rtl/iq_2_ir.sv
// Handshake bundle between the instruction register and the issue queue.
interface IQ_2_IR;
    import tomasula_types::*;

    ctl_word control_word;
    logic    ld_iq;
    logic    issue_q_full_n;
    logic    ack_o;

    modport IQ_SIG (
        input  control_word,
        input  ld_iq,
        output issue_q_full_n,
        output ack_o
    );

    modport IR_SIG (
        output control_word,
        output ld_iq,
        input  issue_q_full_n,
        input  ack_o
    );
endinterface

// File: rtl/instruction_queue_iq_storage.sv
// Entry array for the issue queue: one synchronous write port, one
// asynchronous read port, data left unreset since validity lives in the count.
module iq_storage
    import tomasula_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  ctl_word                  wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output ctl_word                  rd_data
);

    ctl_word mem_r [DEPTH];

    // Write the accepted word into its slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/instruction_queue.sv
// In-order issue queue between the IR and dispatch: accepts control words on
// ld_iq with a one-cycle ack, drains head-first, and empties on flush.
module instruction_queue
    import tomasula_types::*;
#(
    parameter int DEPTH = rv32i_types::IQ_DEPTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  ctl_word control_word,
    input  logic    ld_iq,
    output logic    issue_q_full_n,
    output logic    ack_o,
    input  logic    flush_i,
    input  logic    deq_i,
    output logic    deq_valid_o,
    output ctl_word deq_ctl_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             ack_r;
    logic             full_n_r;
    logic             acc_s;
    logic             pop_s;

    // Space is judged on the pre-edge count, so a pop from full cannot
    // make room for a same-cycle load.
    assign acc_s = ld_iq & (count_r != FULL_COUNT) & ~flush_i;
    assign pop_s = deq_i & (count_r != CNT_ZERO) & ~flush_i;

    // Occupancy after this edge from the accept/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({acc_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r   <= PTR_ZERO;
            tail_r   <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            ack_r    <= 1'b0;
            full_n_r <= 1'b1;
        end else if (flush_i) begin
            head_r   <= PTR_ZERO;
            tail_r   <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            ack_r    <= 1'b0;
            full_n_r <= 1'b1;
        end else begin
            if (acc_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            count_r  <= count_next_s;
            ack_r    <= acc_s;
            full_n_r <= (count_next_s != FULL_COUNT);
        end
    end

    iq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (acc_s),
        .wr_addr (tail_r),
        .wr_data (control_word),
        .rd_addr (head_r),
        .rd_data (deq_ctl_o)
    );

    assign ack_o          = ack_r;
    assign issue_q_full_n = full_n_r;
    assign deq_valid_o    = (count_r != CNT_ZERO);

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed handshake scenarios plus
// randomized traffic against a queue-based reference model.
module tb_instruction_queue;
    import tomasula_types::*;

    localparam int DEPTH = 8;

    logic    clk = 1'b0;
    logic    rst_n;
    ctl_word control_word;
    logic    ld_iq;
    logic    issue_q_full_n;
    logic    ack_o;
    logic    flush_i;
    logic    deq_i;
    logic    deq_valid_o;
    ctl_word deq_ctl_o;

    int n_checks = 0;
    int n_bad    = 0;

    ctl_word mq [$];
    logic    m_ack;
    logic    m_full_n;

    ctl_word a_words [9];
    ctl_word hist [$];
    ctl_word saved_w;
    int      acks;
    int      idx;

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .control_word   (control_word),
        .ld_iq          (ld_iq),
        .issue_q_full_n (issue_q_full_n),
        .ack_o          (ack_o),
        .flush_i        (flush_i),
        .deq_i          (deq_i),
        .deq_valid_o    (deq_valid_o),
        .deq_ctl_o      (deq_ctl_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic ctl_word rand_word();
        return ctl_word'({$urandom(), $urandom()});
    endfunction

    // Reference behaviour of one rising edge, from the pre-edge inputs.
    task automatic model_edge();
        bit had_room;
        if (flush_i) begin
            mq.delete();
            m_ack    = 1'b0;
            m_full_n = 1'b1;
        end else begin
            had_room = (mq.size() < DEPTH);
            if (deq_i && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (ld_iq && had_room) begin
                mq.push_back(control_word);
                m_ack = 1'b1;
            end else begin
                m_ack = 1'b0;
            end
            m_full_n = (mq.size() != DEPTH);
        end
    endtask

    task automatic check_outputs();
        check_eq("valid", 64'(deq_valid_o), 64'(mq.size() != 0));
        check_eq("ack", 64'(ack_o), 64'(m_ack));
        check_eq("full_n", 64'(issue_q_full_n), 64'(m_full_n));
        if (mq.size() != 0) begin
            check_eq("head", deq_ctl_o, mq[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int deq_pct;
        rst_n        = 1'b0;
        control_word = '0;
        ld_iq        = 1'b0;
        flush_i      = 1'b0;
        deq_i        = 1'b0;
        mq.delete();
        m_ack        = 1'b0;
        m_full_n     = 1'b1;
        for (int i = 0; i < 9; i++) a_words[i] = rand_word();

        // Reset, then idle.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_full_n", 64'(issue_q_full_n), 64'd1);
        check_eq("rst_ack", 64'(ack_o), 64'd0);
        check_eq("rst_valid", 64'(deq_valid_o), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Back-to-back load of A0..A7, A8 held while full.
        ld_iq = 1'b1;
        idx = 0;
        control_word = a_words[0];
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ack_o) acks++;
            if (m_ack && idx < 8) begin
                idx++;
                control_word = a_words[idx];
            end
        end
        check_eq("b2b_ack_count", 64'(acks), 64'd8);
        check_eq("full_n_when_full", 64'(issue_q_full_n), 64'd0);

        // Drain from full; A8 goes in once room appears.
        deq_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_order", deq_ctl_o, a_words[i]);
            step();
            if (i == 0) check_eq("full_n_after_pop", 64'(issue_q_full_n), 64'd1);
            if (i == 1) check_eq("held_a8_ack", 64'(ack_o), 64'd1);
            if (m_ack) ld_iq = 1'b0;
        end
        deq_i = 1'b0;
        check_eq("a8_at_head", deq_ctl_o, a_words[8]);
        deq_i = 1'b1;
        step();
        deq_i = 1'b0;
        check_eq("empty_after_drain", 64'(deq_valid_o), 64'd0);

        // Steady enqueue+dequeue at three entries across pointer wrap.
        hist.delete();
        ld_iq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            control_word = rand_word();
            hist.push_back(control_word);
            step();
        end
        deq_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            control_word = rand_word();
            hist.push_back(control_word);
            check_eq("steady_head", deq_ctl_o, hist[k]);
            step();
            check_eq("steady_ack", 64'(ack_o), 64'd1);
        end
        ld_iq = 1'b0;
        for (int i = 0; i < 3; i++) step();
        deq_i = 1'b0;
        check_eq("steady_empty", 64'(deq_valid_o), 64'd0);

        // Flush at five entries with a same-cycle load.
        ld_iq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            control_word = rand_word();
            step();
        end
        flush_i = 1'b1;
        control_word = rand_word();
        step();
        check_eq("flush_valid", 64'(deq_valid_o), 64'd0);
        check_eq("flush_ack", 64'(ack_o), 64'd0);
        check_eq("flush_full_n", 64'(issue_q_full_n), 64'd1);
        flush_i = 1'b0;
        saved_w = rand_word();
        control_word = saved_w;
        step();
        check_eq("post_flush_ack", 64'(ack_o), 64'd1);
        check_eq("post_flush_head", deq_ctl_o, saved_w);
        ld_iq = 1'b0;
        deq_i = 1'b1;
        step();
        deq_i = 1'b0;

        // Asynchronous reset pulse in the middle of a burst.
        ld_iq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            control_word = rand_word();
            step();
        end
        check_eq("pre_reset_ack", 64'(ack_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ack", 64'(ack_o), 64'd0);
        check_eq("async_rst_full_n", 64'(issue_q_full_n), 64'd1);
        check_eq("async_rst_valid", 64'(deq_valid_o), 64'd0);
        mq.delete();
        m_ack    = 1'b0;
        m_full_n = 1'b1;
        ld_iq    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        saved_w = rand_word();
        control_word = saved_w;
        ld_iq = 1'b1;
        step();
        check_eq("restart_head", deq_ctl_o, saved_w);
        ld_iq = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if (m_ack || !ld_iq) control_word = rand_word();
            deq_pct = ((c / 500) % 2 == 1) ? 30 : 75;
            ld_iq   = ($urandom_range(99) < 70);
            deq_i   = ($urandom_range(99) < deq_pct);
            flush_i = ($urandom_range(99) < 2);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

In-order issue queue between the instruction register and dispatch. Sits on the IQ side of the IR-to-IQ handshake: it accepts decoded `tomasula_types::ctl_word` entries when the IR asserts `ld_iq`, acknowledges each accepted entry, and advertises space on `issue_q_full_n`. Entries drain in program order to the dispatch stage. A flush empties the queue on branch mispredict.

## Interface
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `control_word`  in  `ctl_word`  entry from the IR; sampled only when `ld_iq`=1.
- `ld_iq`  in  1  IR load request, level; held by the IR until acknowledged.
- `issue_q_full_n`  out  1  registered; 1 = at least one free entry.
- `ack_o`  out  1  registered one-cycle pulse; the entry offered in the previous cycle was written.
- `flush_i`  in  1  discards all entries and any same-cycle load.
- `deq_i`  in  1  dispatch pops the head entry; ignored when `deq_valid_o`=0.
- `deq_valid_o`  out  1  1 = queue is not empty.
- `deq_ctl_o`  out  `ctl_word`  head entry; valid only while `deq_valid_o`=1.
- Ports 3–6 are exposed to the IR through the `IQ_SIG` modport of `IQ_2_IR`.

## Operation
- State:
  - storage `[DEPTH]` of `ctl_word`
  - `head`, `tail`: `$clog2(DEPTH)` bits each; wrap naturally modulo DEPTH
  - `count`: `$clog2(DEPTH)+1` bits, range 0..DEPTH
- Accept: `acc = ld_iq & (count != DEPTH) & ~flush_i`.
  - On `acc`: write `storage[tail] <= control_word`, `tail++`.
- Pop: `pop = deq_i & (count != 0) & ~flush_i`.
  - On `pop`: `head++`.
- Count update: `count += acc - pop`.
  - Simultaneous `acc` and `pop` leaves `count` unchanged.
  - At `count==DEPTH`, a same-cycle pop does not enable acceptance. Space is judged on the pre-edge count.
- `ack_o` next value equals `acc`, so it is a pulse one cycle after the accepting edge.
  - The IR must not change `control_word` while `ld_iq`=1 and no ack has arrived.
  - The IR may present the next word in the cycle `ack_o` is high.
  - A word that was acknowledged but whose `ld_iq` stays high in the ack cycle is a new request.
- `issue_q_full_n` next value equals `(count_next != DEPTH)`.
- `deq_valid_o = (count != 0)`; `deq_ctl_o = storage[head]`. Both are combinational from registered state.
- `flush_i`: `head <= 0`, `tail <= 0`, `count <= 0`, `ack_o <= 0`, `issue_q_full_n <= 1`. Flush has priority over load and pop. Storage contents are don't-care.
- `ld_iq` while full: the word is not written and no ack is given. The IR keeps holding.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `head`, `tail`, `count` = 0
  - `ack_o` = 0, `issue_q_full_n` = 1, `deq_valid_o` = 0
- Deassertion of reset is synchronous to `clk` via an external synchronizer. Reset asserted mid-operation drops all entries immediately.
- Load-to-ack latency: 1 cycle.
- Load-to-`deq_valid_o` latency: 1 cycle; the entry is visible the cycle after the accepting edge.
- Sustained throughput: one accept per cycle when not full, with the IR pipelining `ld_iq` high.
- `issue_q_full_n` falls in the same cycle the DEPTH-th `ack_o` pulses. It rises the cycle after the first pop from full.

## Structure
- `ctl_word` and any entry-valid typedefs live in `tomasula_types`.
- `DEPTH` default is a constant in `rv32i_types`.
- One sub-module, `iq_storage`:
  - parameterised DEPTH-entry register array
  - one synchronous write port and one asynchronous read port
  - no reset on data
- Pointer, count and handshake logic stay in `instruction_queue`.

## Test plan
- Reset then idle: `issue_q_full_n`=1, `ack_o`=0 and `deq_valid_o`=0 for 5 cycles.
- Back-to-back load: hold `ld_iq`=1 with words A0..A7 advanced on each ack, `deq_i`=0.
  - 8 ack pulses on consecutive cycles.
  - `issue_q_full_n`=0 after the 8th; a 9th word A8 gets no ack.
- Drain from full: assert `deq_i` 8 cycles.
  - `deq_ctl_o` = A0..A7 in order.
  - `issue_q_full_n` returns to 1 one cycle after the first pop.
  - Held A8 acks on the following cycle.
- Simultaneous enqueue and dequeue at count=3 for 20 cycles: count stays 3 and output order matches input order across pointer wrap-around.
- Flush with count=5 and `ld_iq`=1 in the same cycle:
  - next cycle `deq_valid_o`=0, `ack_o`=0, `issue_q_full_n`=1
  - the next load returns its word at head.
- Async reset pulse mid-burst, between clock edges: outputs take reset values immediately, and the queue restarts empty.
